// File: rtl/waveform_playback_buffer_if.sv
// Load and playback stream bundle for waveform_playback_buffer.
// master: sample source/sink side; slave: the buffer.
interface waveform_playback_buffer_if;
    logic [31:0] LoadData;
    logic        LoadValid;
    logic        LoadReady;
    logic [31:0] DataOut;
    logic        DataOutValid;

    modport master (
        output LoadData,
        output LoadValid,
        input  LoadReady,
        input  DataOut,
        input  DataOutValid
    );

    modport slave (
        input  LoadData,
        input  LoadValid,
        output LoadReady,
        output DataOut,
        output DataOutValid
    );
endinterface

// File: rtl/waveform_playback_buffer.sv
// Waveform playback buffer: load words, arm, replay on trigger.
// Continuous looping is built only with PLAYBACK_LOOP_EN defined.
module waveform_playback_buffer #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic                      DataClk,
    input  logic                      Reset,
    waveform_playback_buffer_if.slave bus,
    input  logic                      ArmPlayback,
    input  logic                      ClearBuffer,
    input  logic                      StartTrigger,
    input  logic                      LoopMode,
    output logic                      PlaybackDone,
    output logic [ADDR_W:0]           WordCount,
    output logic                      Busy
);
    typedef enum logic [2:0] {
        LOAD  = 3'b001,
        ARMED = 3'b010,
        PLAY  = 3'b100
    } state_t;

    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     mem [DEPTH];
    logic [ADDR_W:0] rd_ptr;
    logic [31:0]     rd_word;
    logic            rd_valid;
    logic            rd_last;
    logic            out_last;
    logic            write_en;
    logic            last_addr;
    logic            pass_end;
    logic            loop_now;

`ifdef PLAYBACK_LOOP_EN
    assign loop_now = LoopMode;
`else
    logic unused_loop;
    assign unused_loop = LoopMode;
    assign loop_now    = 1'b0;
`endif

    assign bus.LoadReady = (state == LOAD) && (WordCount < FULL) && !Reset;
    assign write_en  = bus.LoadValid && bus.LoadReady;
    assign last_addr = (rd_ptr == WordCount - ONE);
    assign pass_end  = (state == PLAY) && last_addr && !loop_now;
    assign Busy      = (state == PLAY) || rd_valid || bus.DataOutValid;

    always_ff @(posedge DataClk) begin
        if (Reset) state <= LOAD;
        else       state <= state_nxt;
    end

    // A write in the same cycle as ArmPlayback counts toward a non-empty buffer.
    always_comb begin
        state_nxt = state;
        unique case (state)
            LOAD: begin
                if (!ClearBuffer && ArmPlayback &&
                    (WordCount != '0 || write_en))
                    state_nxt = ARMED;
            end
            ARMED: begin
                if (ClearBuffer)       state_nxt = LOAD;
                else if (StartTrigger) state_nxt = PLAY;
            end
            PLAY: begin
                if (pass_end) state_nxt = ARMED;
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge DataClk) begin
        if (Reset) begin
            WordCount <= '0;
            rd_ptr    <= '0;
        end else begin
            if (ClearBuffer && state != PLAY) WordCount <= '0;
            else if (write_en)                WordCount <= WordCount + ONE;

            if (state == ARMED && StartTrigger && !ClearBuffer)
                rd_ptr <= '0;
            else if (state == PLAY)
                rd_ptr <= last_addr ? '0 : rd_ptr + ONE;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge DataClk) begin
        if (write_en && !ClearBuffer)
            mem[WordCount[ADDR_W-1:0]] <= bus.LoadData;
        if (state == PLAY)
            rd_word <= mem[rd_ptr[ADDR_W-1:0]];
    end

    always_ff @(posedge DataClk) begin
        if (Reset) begin
            rd_valid         <= 1'b0;
            rd_last          <= 1'b0;
            bus.DataOutValid <= 1'b0;
            bus.DataOut      <= '0;
            out_last         <= 1'b0;
            PlaybackDone     <= 1'b0;
        end else begin
            rd_valid         <= (state == PLAY);
            rd_last          <= pass_end;
            bus.DataOutValid <= rd_valid;
            bus.DataOut      <= rd_valid ? rd_word : '0;
            out_last         <= rd_valid && rd_last;
            PlaybackDone     <= out_last;
        end
    end
endmodule

// File: tb/tb_waveform_playback_buffer.sv
// Directed bench for waveform_playback_buffer with a playback scoreboard.
// Loop checks follow PLAYBACK_LOOP_EN when it is defined.
module tb_waveform_playback_buffer;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;

    logic            DataClk = 1'b0;
    logic            Reset;
    logic            ArmPlayback;
    logic            ClearBuffer;
    logic            StartTrigger;
    logic            LoopMode;
    logic            PlaybackDone;
    logic [ADDR_W:0] WordCount;
    logic            Busy;

    waveform_playback_buffer_if bus ();

    waveform_playback_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .DataClk      (DataClk),
        .Reset        (Reset),
        .bus          (bus),
        .ArmPlayback  (ArmPlayback),
        .ClearBuffer  (ClearBuffer),
        .StartTrigger (StartTrigger),
        .LoopMode     (LoopMode),
        .PlaybackDone (PlaybackDone),
        .WordCount    (WordCount),
        .Busy         (Busy)
    );

    always #5 DataClk = ~DataClk;

    int          vectors    = 0;
    int          errors     = 0;
    int          words_seen = 0;
    bit          mon_en     = 1'b0;
    logic [31:0] model[$];
    logic [31:0] sb[$];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge DataClk);
        #2;
    endtask

    // Output monitor: every valid word must match the scoreboard head.
    always @(posedge DataClk) begin
        #1;
        if (mon_en) begin
            if (bus.DataOutValid === 1'b1) begin
                words_seen++;
                if (sb.size() == 0)
                    check("sb_underflow", 64'(sb.size()), 64'd1);
                else
                    check("data_out", bus.DataOut, sb.pop_front());
            end else begin
                check("data_out_idle_zero", bus.DataOut, 0);
            end
        end
    end

    task automatic load_words(input int n);
        logic [31:0] d;
        model.delete();
        for (int i = 0; i < n; i++) begin
            d = (n <= 4) ? 32'(32'h1111_1111 * (i + 1)) : $urandom;
            bus.LoadData  = d;
            bus.LoadValid = 1'b1;
            #1;
            check("load_ready", bus.LoadReady, 1);
            tick();
            model.push_back(d);
        end
        bus.LoadValid = 1'b0;
        check("word_count_loaded", WordCount, n);
    endtask

    task automatic arm();
        ArmPlayback = 1'b1;
        tick();
        ArmPlayback = 1'b0;
        check("armed_not_ready", bus.LoadReady, 0);
        check("armed_idle", Busy, 0);
    endtask

    task automatic clear();
        ClearBuffer = 1'b1;
        tick();
        ClearBuffer = 1'b0;
        check("clear_count", WordCount, 0);
        check("clear_ready", bus.LoadReady, 1);
    endtask

    task automatic run_play(input int n, input bit disturb,
                            input bit loop_on, input int drop_k);
        int done_k = 0;
        int seen0;
        for (int i = 0; i < n; i++)
            sb.push_back(model[i % model.size()]);
        seen0        = words_seen;
        LoopMode     = loop_on;
        StartTrigger = 1'b1;
        tick();
        StartTrigger = 1'b0;
        check("busy_in_play", Busy, 1);
        if (disturb) begin
            ClearBuffer   = 1'b1;
            ArmPlayback   = 1'b1;
            StartTrigger  = 1'b1;
            bus.LoadValid = 1'b1;
            bus.LoadData  = 32'hDEAD_BEEF;
        end
        for (int k = 1; k <= n + 20 && done_k == 0; k++) begin
            tick();
            if (k == 1) begin
                ClearBuffer   = 1'b0;
                ArmPlayback   = 1'b0;
                StartTrigger  = 1'b0;
                bus.LoadValid = 1'b0;
                check("valid_at_t1", bus.DataOutValid, 0);
            end
            if (drop_k != 0 && k == drop_k) LoopMode = 1'b0;
            if (PlaybackDone === 1'b1) done_k = k;
        end
        LoopMode = 1'b0;
        check("done_cycle", done_k, n + 2);
        check("words_played", words_seen - seen0, n);
        check("sb_drained", sb.size(), 0);
        check("busy_after_done", Busy, 0);
        check("armed_after_done", bus.LoadReady, 0);
        tick();
        check("done_one_pulse", PlaybackDone, 0);
    endtask

    initial begin
        int accepted;
        logic [31:0] d;
        Reset         = 1'b1;
        ArmPlayback   = 1'b0;
        ClearBuffer   = 1'b0;
        StartTrigger  = 1'b0;
        LoopMode      = 1'b0;
        bus.LoadData  = '0;
        bus.LoadValid = 1'b0;
        tick();
        tick();
        mon_en = 1'b1;
        check("rst_word_count", WordCount, 0);
        check("rst_valid", bus.DataOutValid, 0);
        check("rst_data", bus.DataOut, 0);
        check("rst_done", PlaybackDone, 0);
        check("rst_busy", Busy, 0);
        check("rst_ready_low", bus.LoadReady, 0);
        Reset = 1'b0;
        #1;
        check("ready_after_reset", bus.LoadReady, 1);

        // Four-word load, playback, then retrigger of the same contents.
        load_words(4);
        arm();
        run_play(4, 1'b0, 1'b0, 0);
        run_play(4, 1'b0, 1'b0, 0);

        // Clear in ARMED, then stray controls in LOAD.
        clear();
        StartTrigger = 1'b1;
        tick();
        StartTrigger = 1'b0;
        check("trig_in_load_busy", Busy, 0);
        tick();
        tick();
        check("trig_in_load_valid", bus.DataOutValid, 0);
        ArmPlayback = 1'b1;
        tick();
        ArmPlayback = 1'b0;
        check("arm_empty_ready", bus.LoadReady, 1);
        check("arm_empty_count", WordCount, 0);

        // Clear wins over a same-cycle write.
        load_words(1);
        bus.LoadData  = 32'h5555_AAAA;
        bus.LoadValid = 1'b1;
        ClearBuffer   = 1'b1;
        tick();
        bus.LoadValid = 1'b0;
        ClearBuffer   = 1'b0;
        check("clear_beats_write", WordCount, 0);

        // Arm from empty with a same-cycle write: one-word buffer.
        model.delete();
        bus.LoadData  = 32'hA5A5_5A5A;
        bus.LoadValid = 1'b1;
        ArmPlayback   = 1'b1;
        tick();
        bus.LoadValid = 1'b0;
        ArmPlayback   = 1'b0;
        model.push_back(32'hA5A5_5A5A);
        check("arm_with_write_count", WordCount, 1);
        check("arm_with_write_state", bus.LoadReady, 0);
        run_play(1, 1'b0, 1'b0, 0);

        // Controls during PLAY are ignored.
        clear();
        load_words(2);
        arm();
        run_play(2, 1'b1, 1'b0, 0);
        check("count_after_disturb", WordCount, 2);

        // Overfill: 130 offered, 128 accepted.
        clear();
        model.delete();
        accepted      = 0;
        bus.LoadValid = 1'b1;
        for (int i = 0; i < 130; i++) begin
            d            = $urandom;
            bus.LoadData = d;
            #1;
            if (bus.LoadReady === 1'b1) begin
                model.push_back(d);
                accepted++;
            end
            tick();
        end
        bus.LoadValid = 1'b0;
        check("full_accepted", accepted, DEPTH);
        check("full_count", WordCount, DEPTH);
        check("full_not_ready", bus.LoadReady, 0);
        arm();
        run_play(DEPTH, 1'b0, 1'b0, 0);

        // Loop mode: repeat until LoopMode drops mid-pass.
        clear();
        load_words(3);
        arm();
`ifdef PLAYBACK_LOOP_EN
        run_play(6, 1'b0, 1'b1, 4);
`else
        run_play(3, 1'b0, 1'b1, 0);
`endif

        // Reset at the second output word.
        clear();
        load_words(4);
        arm();
        for (int i = 0; i < 4; i++) sb.push_back(model[i]);
        StartTrigger = 1'b1;
        tick();
        StartTrigger = 1'b0;
        tick();
        tick();
        tick();
        check("second_word_valid", bus.DataOutValid, 1);
        Reset = 1'b1;
        tick();
        check("reset_drops_valid", bus.DataOutValid, 0);
        check("reset_no_done", PlaybackDone, 0);
        sb.delete();
        tick();
        check("reset_no_done_2", PlaybackDone, 0);
        Reset = 1'b0;
        #1;
        check("reset_count", WordCount, 0);
        check("reset_ready", bus.LoadReady, 1);
        tick();
        check("reset_no_done_3", PlaybackDone, 0);
        check("reset_idle_valid", bus.DataOutValid, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end
endmodule

// File: doc/waveform_playback_buffer.md
WAVEFORM_PLAYBACK_BUFFER -- requirements
Module: waveform_playback_buffer

Interface
REQ-001 Parameter DEPTH, default 128: buffer depth in 32-bit words, power of two.
REQ-002 Parameter ADDR_W, default 7: log2(DEPTH).
REQ-003 DataClk  in  1  sole clock; ADC/DAC sample clock (~250 MHz); all logic on rising edge.
REQ-004 Reset  in  1  synchronous, active-high; clock DataClk.
REQ-005 LoadData  in  32  word to store; four 8-bit samples, [31:24] oldest.
REQ-006 LoadValid  in  1  LoadData valid this cycle.
REQ-007 LoadReady  out  1  buffer accepts a word this cycle.
REQ-008 ArmPlayback  in  1  level; arms the loaded buffer for triggered playback.
REQ-009 ClearBuffer  in  1  one-cycle pulse; discards buffer contents.
REQ-010 StartTrigger  in  1  synchronous with DataClk; starts playback.
REQ-011 LoopMode  in  1  repeat buffer continuously (PLAYBACK_LOOP_EN only).
REQ-012 DataOut  out  32  played-back word.
REQ-013 DataOutValid  out  1  DataOut holds a playback word.
REQ-014 PlaybackDone  out  1  one-cycle pulse after the last word of a pass sequence.
REQ-015 WordCount  out  ADDR_W+1  words currently stored (0..DEPTH).
REQ-016 Busy  out  1  high in PLAY or while the read pipeline holds a word.

Function
REQ-017 The block SHALL be a one-hot FSM with states LOAD, ARMED, PLAY.
REQ-018 LoadReady SHALL equal (state==LOAD) and (WordCount<DEPTH) and not Reset.
REQ-019 In LOAD, LoadValid&LoadReady SHALL write LoadData to mem[WordCount] and increment WordCount by 1.
REQ-020 LoadValid while LoadReady=0 SHALL be dropped, with no state, pointer or count change.
REQ-021 LOAD->ARMED SHALL occur when ArmPlayback=1 and the count after this cycle's write is >0; a same-cycle write SHALL be included in the count.
REQ-022 ArmPlayback with WordCount=0 and no write SHALL be ignored.
REQ-023 ARMED->LOAD SHALL occur on ClearBuffer, with WordCount cleared to 0; ClearBuffer in LOAD SHALL clear WordCount and take priority over a same-cycle write.
REQ-024 ARMED->PLAY SHALL occur on StartTrigger=1 with ClearBuffer=0, and the read pointer SHALL be set to 0.
REQ-025 Memory read SHALL have 1-cycle registered latency.
REQ-026 Playback timing: trigger sampled at edge T -> PLAY from T+1 -> word 0 on DataOut with DataOutValid=1 after edge T+2.
REQ-027 Words 0..WordCount-1 SHALL be emitted on consecutive cycles with no gaps.
REQ-028 After the last address is issued, PLAY->ARMED SHALL occur.
REQ-029 PlaybackDone SHALL pulse in the cycle after the last word's DataOutValid cycle.
REQ-030 StartTrigger, ArmPlayback, ClearBuffer and LoadValid SHALL be ignored in PLAY.
REQ-031 StartTrigger in LOAD SHALL be ignored.
REQ-032 A retrigger in ARMED SHALL replay the same contents.
REQ-033 DataOut SHALL be 0 whenever DataOutValid=0.
REQ-034 The read pointer SHALL be ADDR_W+1 bits wide, compared against WordCount; a DEPTH-word buffer plays all DEPTH words.

Reset
REQ-035 Reset SHALL force state LOAD and clear WordCount, read pointer, DataOut, DataOutValid, PlaybackDone and Busy to 0.
REQ-036 Memory contents SHALL NOT be cleared by Reset.
REQ-037 Reset mid-PLAY SHALL drop DataOutValid to 0 at the next edge, with no PlaybackDone pulse.

Configuration
REQ-038 With macro PLAYBACK_LOOP_EN defined, and LoopMode=1 when the last address is issued, the read pointer SHALL wrap to 0 with no gap cycle and state SHALL remain PLAY.
REQ-039 With PLAYBACK_LOOP_EN defined, the loop SHALL end at the end of the first pass that completes with LoopMode=0; PlaybackDone SHALL pulse once, only then.
REQ-040 Without PLAYBACK_LOOP_EN, the LoopMode port SHALL remain present but be ignored, and playback SHALL be single-pass only.

Verification
REQ-041 Reset -> load 4 words 0x11111111..0x44444444 -> LoadReady=1 throughout, WordCount=4.
REQ-042 Arm, trigger at edge T -> four words in order on T+2..T+5, PlaybackDone at T+6, Busy low after, state ARMED; retrigger -> identical output.
REQ-043 Load 130 words with LoadValid held high -> LoadReady=0 after 128 accepted, WordCount=128, words 129-130 dropped; playback emits 128 words.
REQ-044 Trigger in LOAD, ArmPlayback with WordCount=0, ClearBuffer during PLAY -> all ignored; ClearBuffer in ARMED -> LOAD, WordCount=0.
REQ-045 PLAYBACK_LOOP_EN, 3 words, LoopMode=1 -> repeating W0 W1 W2 W0... with no gaps; drop LoopMode mid-pass -> pass completes, one PlaybackDone.
REQ-046 Reset asserted at the 2nd output word -> DataOutValid=0 next cycle, no PlaybackDone, WordCount=0, LoadReady=1 after release.
